ahb_master: RTL and testbench
=============================

// Module: ahb_master
// PURPOSE
//  AHB-Lite initiator: turns a simple valid/ready command stream into single AHB transfers.
//  Drives haddr/htrans/hwrite/hsize/hwdata toward the decoder and slaves.
//  Consumes hrdata/hready/hresp returned through the slave read-data multiplexer.
//  Address phase of command N+1 overlaps the data phase of command N (full pipelining).
// PARAMETERS
//  ADDR_W      32   address width
//  DATA_W      32   data width (hrdata/hwdata)
//  TIMEOUT     255  wait-state limit, used only with AHB_MASTER_TIMEOUT_EN (8-bit counter)
// PORTS
//  hclk       in   1       clock
//  hresetn    in   1       asynchronous active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid&&cmd_ready at posedge
//  cmd_write  in   1       1=write, 0=read
//  cmd_addr   in   ADDR_W  byte address
//  cmd_size   in   3       AHB hsize encoding (000 byte, 001 half, 010 word)
//  cmd_wdata  in   DATA_W  write data
//  rsp_valid  out  1       one-cycle pulse: a transfer completed (no backpressure)
//  rsp_rdata  out  DATA_W  captured hrdata (reads); 0 for writes
//  rsp_err    out  1       transfer ended with ERROR response (or timeout)
//  haddr      out  ADDR_W  AHB address
//  htrans     out  2       IDLE=00 or NONSEQ=10 only
//  hwrite     out  1       AHB direction
//  hsize      out  3       AHB size
//  hburst     out  3       tied 000 (SINGLE)
//  hwdata     out  DATA_W  write data, driven during data phase
//  hrdata     in   DATA_W  read data from slave mux
//  hready     in   1       transfer-done / bus-advance
//  hresp      in   1       0=OKAY, 1=ERROR
// BEHAVIOUR
//  Reset: htrans=IDLE, haddr/hwrite/hsize/hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//  Two registered stages: A (address phase valid + fields) and D (data phase valid + hwrite + wdata).
//  cmd_ready = hready && !err_cancel (A stage empty or advancing); combinational, no cmd_valid dependency.
//  Accept -> next cycle A loaded: haddr/hwrite/hsize set, htrans=NONSEQ; hold stable while hready=0.
//  hready=1 with A valid: A moves to D; hwdata = that cmd's wdata from the next cycle.
//  hready=1 with D valid: transfer completes; rsp_valid=1 next cycle, rsp_rdata=hrdata (read) else 0.
//  Accept and completion in same cycle is legal; throughput one transfer per cycle at zero wait.
//  No command pending: htrans=IDLE, haddr holds last value.
//  ERROR: D valid, hresp=1, hready=0 (1st error cycle): next cycle htrans forced IDLE, A retained (err_cancel=1).
//   2nd error cycle (hresp=1, hready=1): D completes with rsp_err=1; A re-issued as NONSEQ next cycle.
//  hresp=1 with hready=1 without a prior hresp=1/hready=0 cycle: treated as ERROR completion, rsp_err=1.
//  Reset asserted mid-transfer: all stages dropped immediately, no rsp for in-flight commands.
// CONFIGURATION
//  AHB_MASTER_TIMEOUT_EN defined: counter counts consecutive hready=0 cycles in D; reaching TIMEOUT
//   ends the transfer locally: rsp_valid=1, rsp_err=1, D cleared, htrans=IDLE for one cycle, A retained.
//  Undefined: no counter; master waits on hready indefinitely.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS_IDLE/NONSEQ, HSIZE_BYTE/HALF/WORD, HBURST_SINGLE, HRESP_OKAY/ERROR.
//  One sub-module: ahb_master_watchdog (counter + expiry pulse), instantiated only under the macro.
// TESTING
//  Read 0x0000_0010, zero wait, hrdata=0xDEAD_BEEF -> NONSEQ 1 cycle, rsp_valid 2 cycles later, rdata=0xDEAD_BEEF, err=0.
//  Write 0x20 data 0x1234_5678 then read 0x24 back-to-back -> haddr 0x24 in same cycle hwdata=0x1234_5678.
//  Read with hready low 3 cycles -> haddr/htrans held stable, one rsp_valid after hready rises.
//  Write 0x30 gets ERROR (2-cycle) with read 0x34 pending -> htrans IDLE in cycle 2, rsp_err=1, 0x34 re-issued.
//  hresetn low during wait state -> all outputs reset values, no rsp_valid afterward.
//  With AHB_MASTER_TIMEOUT_EN, TIMEOUT=4, hready held low -> rsp_err=1 after 4 wait cycles.

Source files
------------

// File: rtl/ahb_pkg.sv
// ==== ahb_pkg: AHB-Lite transfer encodings shared by the initiator ====
// ==== Rev 1.0 ====
`default_nettype none

package ahb_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ahb_master_watchdog.sv
// ==== ahb_master_watchdog: counts consecutive data-phase wait states, pulses on limit ====
// ==== Rev 1.0 ====
`default_nettype none

module ahb_master_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic hclk,
   input  logic hresetn,
   input  logic active_i,
   input  logic stall_i,
   output logic expire_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      expire_o = active_i && stall_i && (cnt_q == 8'(TIMEOUT - 1));
      cnt_d    = '0;
      // Restart after expiry so the next data phase gets a full budget.
      if (active_i && stall_i && !expire_o) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ahb_master.sv
// ==== ahb_master: pipelined AHB-Lite initiator; AHB_MASTER_TIMEOUT_EN adds a wait-state watchdog ====
// ==== Rev 1.0 ====
`default_nettype none

module ahb_master
   import ahb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [2:0]        cmd_size,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] haddr,
   output logic [1:0]        htrans,
   output logic              hwrite,
   output logic [2:0]        hsize,
   output logic [2:0]        hburst,
   output logic [DATA_W-1:0] hwdata,
   input  logic [DATA_W-1:0] hrdata,
   input  logic              hready,
   input  logic              hresp
);

   logic              a_valid_q, a_valid_d;
   logic [ADDR_W-1:0] a_addr_q,  a_addr_d;
   logic              a_write_q, a_write_d;
   logic [2:0]        a_size_q,  a_size_d;
   logic [DATA_W-1:0] a_wdata_q, a_wdata_d;
   logic              d_valid_q, d_valid_d;
   logic              d_write_q, d_write_d;
   logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
   logic              cancel_q,  cancel_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q,   rsp_err_d;

   logic accept;
   logic a_fire;
   logic d_done;
   logic expire;

`ifdef AHB_MASTER_TIMEOUT_EN
   ahb_master_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .hclk     (hclk),
      .hresetn  (hresetn),
      .active_i (d_valid_q),
      .stall_i  (!hready),
      .expire_o (expire)
   );
`else
   assign expire = 1'b0;
`endif

   // cancel_q blanks the pending address phase for one cycle after an
   // ERROR first cycle or a local timeout; the command stays in A.
   assign cmd_ready = hready && !cancel_q;
   assign htrans    = (a_valid_q && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign haddr     = a_addr_q;
   assign hwrite    = a_write_q;
   assign hsize     = a_size_q;
   assign hburst    = HBURST_SINGLE;
   assign hwdata    = d_wdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

   always_comb begin
      accept      = cmd_valid && cmd_ready;
      a_fire      = a_valid_q && !cancel_q && hready;
      d_done      = d_valid_q && hready;

      a_valid_d   = a_valid_q;
      a_addr_d    = a_addr_q;
      a_write_d   = a_write_q;
      a_size_d    = a_size_q;
      a_wdata_d   = a_wdata_q;
      d_valid_d   = d_valid_q;
      d_write_d   = d_write_q;
      d_wdata_d   = d_wdata_q;
      rsp_rdata_d = rsp_rdata_q;

      if (accept) begin
         a_valid_d = 1'b1;
         a_addr_d  = cmd_addr;
         a_write_d = cmd_write;
         a_size_d  = cmd_size;
         a_wdata_d = cmd_wdata;
      end else if (a_fire) begin
         a_valid_d = 1'b0;
      end

      if (a_fire) begin
         d_valid_d = 1'b1;
         d_write_d = a_write_q;
         d_wdata_d = a_wdata_q;
      end else if (d_done || expire) begin
         d_valid_d = 1'b0;
      end

      rsp_valid_d = d_done || expire;
      rsp_err_d   = (d_done && (hresp == HRESP_ERROR)) || expire;
      if (d_done) begin
         rsp_rdata_d = d_write_q ? '0 : hrdata;
      end else if (expire) begin
         rsp_rdata_d = '0;
      end

      cancel_d = (d_valid_q && (hresp == HRESP_ERROR) && !hready) || expire;
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         a_valid_q   <= 1'b0;
         a_addr_q    <= '0;
         a_write_q   <= 1'b0;
         a_size_q    <= '0;
         a_wdata_q   <= '0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         d_wdata_q   <= '0;
         cancel_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         a_valid_q   <= a_valid_d;
         a_addr_q    <= a_addr_d;
         a_write_q   <= a_write_d;
         a_size_q    <= a_size_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         d_wdata_q   <= d_wdata_d;
         cancel_q    <= cancel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_master.sv
// ==== tb_ahb_master: directed and randomized checks of ahb_master against an AHB protocol model ====
// ==== Rev 1.0 ====
`default_nettype none

module tb_ahb_master;

`ifdef AHB_MASTER_TIMEOUT_EN
   localparam int TO    = 4;
   localparam bit TO_ON = 1'b1;
`else
   localparam int TO    = 255;
   localparam bit TO_ON = 1'b0;
`endif

   logic        hclk = 1'b0;
   logic        hresetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [2:0]  cmd_size;
   logic        rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   logic [31:0] haddr, hwdata, hrdata;
   logic [1:0]  htrans;
   logic        hwrite, hready, hresp;
   logic [2:0]  hsize, hburst;

   ahb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .hclk(hclk), .hresetn(hresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
      .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
      .hresp(hresp)
   );

   always #5 hclk = ~hclk;

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [2:0]  s;
      logic [31:0] d;
   } cmd_t;

   int          checks = 0;
   int          errors = 0;
   cmd_t        cmdq[$];
   cmd_t        dp_cmd;
   bit          dp_active = 1'b0;
   bit          dp_new    = 1'b0;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_addr = '0;
   int          wait_run  = 0;
   logic [1:0]  o_htrans;
   logic [31:0] o_haddr, o_hwdata;
   logic        o_cmd_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cmdq.delete();
      dp_active = 1'b0;
      dp_new    = 1'b0;
      prev_hold = 1'b0;
      wait_run  = 0;
   endtask

   // One bus cycle: drive inputs, check the bus against the protocol model,
   // clock, then check the response against what the model says completed.
   task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d, input bit rdy, input bit rsp, input logic [31:0] rd);
      bit          acc, tmo, exp_rv, exp_err;
      logic [31:0] exp_rd;
      cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
      hready = rdy; hresp = rsp; hrdata = rd;
      #1;
      o_htrans = htrans; o_haddr = haddr; o_hwdata = hwdata; o_cmd_ready = cmd_ready;
      acc = v && cmd_ready;
      exp_rv = 1'b0; exp_err = 1'b0; exp_rd = '0; tmo = 1'b0;
      chk("hburst", {61'd0, hburst}, 64'd0);
      if (prev_hold) begin
         chk("hold_htrans", {62'd0, htrans}, 64'd2);
         chk("hold_haddr", {32'd0, haddr}, {32'd0, prev_addr});
      end
      if (htrans == 2'b10) begin
         if (cmdq.size() == 0) begin
            chk("spurious_nonseq", 64'd1, 64'd0);
         end else begin
            chk("haddr", {32'd0, haddr}, {32'd0, cmdq[0].a});
            chk("hwrite", {63'd0, hwrite}, {63'd0, cmdq[0].w});
            chk("hsize", {61'd0, hsize}, {61'd0, cmdq[0].s});
         end
      end else begin
         chk("htrans_legal", {62'd0, htrans}, 64'd0);
      end
      if (dp_active) begin
         if (rdy) begin
            exp_rv  = 1'b1;
            exp_rd  = dp_cmd.w ? 32'd0 : rd;
            exp_err = rsp;
            if (dp_cmd.w) chk("hwdata", {32'd0, hwdata}, {32'd0, dp_cmd.d});
         end else begin
            wait_run++;
            if (TO_ON && wait_run == TO) begin
               exp_rv = 1'b1; exp_err = 1'b1; exp_rd = '0; tmo = 1'b1;
            end
         end
      end
      prev_hold = (htrans == 2'b10) && !rdy && !rsp && !tmo;
      prev_addr = haddr;
      if (rdy) begin
         if (htrans == 2'b10 && cmdq.size() > 0) begin
            dp_cmd = cmdq.pop_front(); dp_active = 1'b1; dp_new = 1'b1; wait_run = 0;
         end else begin
            dp_active = 1'b0;
         end
      end else if (tmo) begin
         dp_active = 1'b0;
      end
      if (acc) cmdq.push_back('{w: w, a: a, s: s, d: d});
      @(posedge hclk);
      #1;
      chk("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_rv});
      if (exp_rv) begin
         chk("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
         chk("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
      end
   endtask

   task automatic idle(input bit rdy, input bit rsp, input logic [31:0] rd);
      step(1'b0, 1'b0, 32'd0, 3'd0, 32'd0, rdy, rsp, rd);
   endtask

   bit          rv, rw, rrdy, rrsp;
   logic [2:0]  rs;
   logic [31:0] ra;
   int          sl_wait, sl_err, pick;
   bit          sl_e1;

   initial begin
      hresetn = 1'b0;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      #12;
      chk("rst_htrans", {62'd0, htrans}, 64'd0);
      chk("rst_haddr", {32'd0, haddr}, 64'd0);
      chk("rst_hwrite", {63'd0, hwrite}, 64'd0);
      chk("rst_hsize", {61'd0, hsize}, 64'd0);
      chk("rst_hwdata", {32'd0, hwdata}, 64'd0);
      chk("rst_rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
      @(negedge hclk);
      hresetn = 1'b1;
      @(posedge hclk);
      #1;

      // Single zero-wait read.
      step(1'b1, 1'b0, 32'h10, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      idle(1'b1, 1'b0, 32'd0);
      chk("rd_nonseq", {62'd0, o_htrans}, 64'd2);
      chk("rd_addr", {32'd0, o_haddr}, 64'h10);
      idle(1'b1, 1'b0, 32'hDEAD_BEEF);
      chk("rd_idle_after", {62'd0, o_htrans}, 64'd0);
      chk("rd_data", {32'd0, rsp_rdata}, 64'hDEAD_BEEF);

      // Back-to-back write then read: address of the read overlaps write data.
      step(1'b1, 1'b1, 32'h20, 3'd2, 32'h1234_5678, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h24, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      idle(1'b1, 1'b0, 32'd0);
      chk("b2b_haddr", {32'd0, o_haddr}, 64'h24);
      chk("b2b_htrans", {62'd0, o_htrans}, 64'd2);
      chk("b2b_hwdata", {32'd0, o_hwdata}, 64'h1234_5678);
      idle(1'b1, 1'b0, 32'hCAFE_F00D);
      chk("b2b_rdata", {32'd0, rsp_rdata}, 64'hCAFE_F00D);

      // Three wait states with a second command parked in the address phase.
      step(1'b1, 1'b0, 32'h3C, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h40, 3'd1, 32'd0, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 3; i++) idle(1'b0, 1'b0, 32'd0);
      chk("wait_haddr", {32'd0, o_haddr}, 64'h40);
      idle(1'b1, 1'b0, 32'h1111_1111);
      idle(1'b1, 1'b0, 32'h2222_2222);

      // Two-cycle ERROR on a write with a read pending.
      step(1'b1, 1'b1, 32'h30, 3'd2, 32'hA5A5_0001, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h34, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      idle(1'b0, 1'b1, 32'd0);
      idle(1'b1, 1'b1, 32'd0);
      chk("err_htrans_idle", {62'd0, o_htrans}, 64'd0);
      chk("err_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
      chk("err_rsp_err", {63'd0, rsp_err}, 64'd1);
      idle(1'b1, 1'b0, 32'd0);
      chk("err_reissue", {62'd0, o_htrans}, 64'd2);
      chk("err_reissue_addr", {32'd0, o_haddr}, 64'h34);
      idle(1'b1, 1'b0, 32'h3434_3434);

      // Single-cycle ERROR without a preceding wait cycle.
      step(1'b1, 1'b0, 32'h44, 3'd0, 32'd0, 1'b1, 1'b0, 32'd0);
      idle(1'b1, 1'b0, 32'd0);
      idle(1'b1, 1'b1, 32'h0BAD_0BAD);

`ifdef AHB_MASTER_TIMEOUT_EN
      step(1'b1, 1'b0, 32'h60, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h64, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      for (int i = 0; i < TO; i++) idle(1'b0, 1'b0, 32'd0);
      chk("tmo_rsp_err", {62'd0, rsp_valid, rsp_err}, 64'd3);
      idle(1'b1, 1'b0, 32'd0);
      chk("tmo_idle", {62'd0, o_htrans}, 64'd0);
      idle(1'b1, 1'b0, 32'd0);
      chk("tmo_reissue", {32'd0, o_haddr}, 64'h64);
      idle(1'b1, 1'b0, 32'h6464_6464);
`endif

      // Reset during a wait state drops everything in flight.
      step(1'b1, 1'b1, 32'h50, 3'd2, 32'hAAAA_5555, 1'b1, 1'b0, 32'd0);
      step(1'b1, 1'b0, 32'h54, 3'd2, 32'd0, 1'b1, 1'b0, 32'd0);
      idle(1'b0, 1'b0, 32'd0);
      hresetn = 1'b0;
      cmd_valid = 1'b0;
      #1;
      chk("mid_rst_htrans", {62'd0, htrans}, 64'd0);
      chk("mid_rst_haddr", {32'd0, haddr}, 64'd0);
      chk("mid_rst_hwrite", {61'd0, hwrite, hsize[1:0]}, 64'd0);
      chk("mid_rst_hwdata", {32'd0, hwdata}, 64'd0);
      chk("mid_rst_rsp", {30'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
      model_reset();
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b0, 32'hFFFF_FFFF);

      // Randomized traffic against a randomly stalling, occasionally erroring slave.
      dp_new = 1'b0;
      sl_wait = 0; sl_err = 0; sl_e1 = 1'b0;
      for (int i = 0; i < 400; i++) begin
         rv = ($urandom_range(0, 3) != 0);
         rw = $urandom_range(0, 1) == 1;
         rs = 3'($urandom_range(0, 2));
         ra = $urandom & ~((32'd1 << rs) - 32'd1);
         if (dp_active && dp_new) begin
            sl_wait = $urandom_range(0, 2);
            pick    = $urandom_range(0, 9);
            sl_err  = (pick == 0) ? 1 : (pick == 1) ? 2 : 0;
            sl_e1   = 1'b0;
            dp_new  = 1'b0;
         end
         if (!dp_active) begin
            rrdy = 1'b1; rrsp = 1'b0;
         end else if (sl_wait > 0) begin
            rrdy = 1'b0; rrsp = 1'b0; sl_wait--;
         end else if (sl_err == 1 && !sl_e1) begin
            rrdy = 1'b0; rrsp = 1'b1; sl_e1 = 1'b1;
         end else begin
            rrdy = 1'b1; rrsp = (sl_err != 0);
         end
         step(rv, rw, ra, rs, $urandom, rrdy, rrsp, $urandom);
      end

      for (int i = 0; i < 20 && (cmdq.size() > 0 || dp_active); i++) begin
         idle(1'b1, 1'b0, $urandom);
      end
      chk("drained", {32'd0, 32'(cmdq.size()) + {31'd0, dp_active}}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
